// File: rtl/tetris_video_pkg.sv
// Shared timing, board geometry, colour types and palette
// for the Tetris frame renderer.
package tetris_video_pkg;

    localparam int VGA_H_VIS   = 640;
    localparam int VGA_H_FP    = 16;
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BP    = 48;
    localparam int VGA_V_VIS   = 480;
    localparam int VGA_V_FP    = 10;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BP    = 33;
    localparam int VGA_H_TOTAL =
        VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL =
        VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam bit VGA_SYNC_POL = 1'b0;

    localparam int BOARD_COLS    = 10;
    localparam int BOARD_ROWS    = 20;
    localparam int BRD_CELL_PX   = 16;
    localparam int BRD_X0        = 240;
    localparam int BRD_Y0        = 80;
    localparam int BRD_BORDER_PX = 4;

    localparam int CNT_W = 10;

    typedef logic [CNT_W-1:0] hcnt_t;
    typedef logic [CNT_W-1:0] vcnt_t;
    typedef logic [2:0]       color_t;
    typedef logic [23:0]      rgb_t;

    typedef enum logic [1:0] {
        REG_BG,
        REG_BORDER,
        REG_BOARD
    } region_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

    typedef struct packed {
        sync_t   sy;
        region_t region;
        color_t  color;
    } s1_t;

    localparam rgb_t BORDER_RGB = 24'h808080;
    localparam rgb_t BG_RGB     = 24'h101010;

    function automatic rgb_t palette(input color_t c);
        rgb_t rgb;
        unique case (c)
            3'd0: rgb = 24'h000000;
            3'd1: rgb = 24'h00FFFF;
            3'd2: rgb = 24'hFFFF00;
            3'd3: rgb = 24'h800080;
            3'd4: rgb = 24'h00FF00;
            3'd5: rgb = 24'hFF0000;
            3'd6: rgb = 24'h0000FF;
            3'd7: rgb = 24'hFF8000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/tetris_frame_renderer_if.sv
// Cell-store write port between game logic (master)
// and the frame renderer (slave).
interface tetris_frame_renderer_if;
    import tetris_video_pkg::*;

    logic       cell_we;
    logic [3:0] cell_x;
    logic [4:0] cell_y;
    color_t     cell_color;

    modport master (
        output cell_we,
        output cell_x,
        output cell_y,
        output cell_color
    );

    modport slave (
        input cell_we,
        input cell_x,
        input cell_y,
        input cell_color
    );

endinterface

// File: rtl/video_timing_counter.sv
// Raster counters with raw de/hsync/vsync and a registered
// one-cycle frame_tick at the start of vertical blank.
module video_timing_counter
    import tetris_video_pkg::*;
#(
    parameter int H_VIS    = VGA_H_VIS,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_VIS    = VGA_V_VIS,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = VGA_SYNC_POL
) (
    input  logic  pixclk,
    input  logic  rst_n,
    output hcnt_t hcnt,
    output vcnt_t vcnt,
    output sync_t raw,
    output logic  frame_tick
);

    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG = H_VIS + H_FP;
    localparam int HS_END = HS_BEG + H_SYNC;
    localparam int VS_BEG = V_VIS + V_FP;
    localparam int VS_END = VS_BEG + V_SYNC;

    logic h_last;
    logic v_last;
    logic hs_act;
    logic vs_act;
    logic tick_hit;

    always_comb begin
        h_last   = hcnt == hcnt_t'(H_TOT - 1);
        v_last   = vcnt == vcnt_t'(V_TOT - 1);
        hs_act   = (hcnt >= hcnt_t'(HS_BEG))
                && (hcnt <  hcnt_t'(HS_END));
        vs_act   = (vcnt >= vcnt_t'(VS_BEG))
                && (vcnt <  vcnt_t'(VS_END));
        tick_hit = (hcnt == '0)
                && (vcnt == vcnt_t'(V_VIS));
        raw.de   = (hcnt < hcnt_t'(H_VIS))
                && (vcnt < vcnt_t'(V_VIS));
        raw.hs   = hs_act ? SYNC_POL : ~SYNC_POL;
        raw.vs   = vs_act ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt       <= '0;
            vcnt       <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= tick_hit;
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tetris_frame_renderer.sv
// 640x480 raster with a 10x20 Tetris board, 2-cycle pixel pipeline.
// Define TETRIS_BOARD_DBUF_EN for a tear-free shadow/display cell store.
module tetris_frame_renderer
    import tetris_video_pkg::*;
#(
    parameter int H_VIS     = VGA_H_VIS,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_VIS     = VGA_V_VIS,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int CELL_PX   = BRD_CELL_PX,
    parameter int BOARD_X0  = BRD_X0,
    parameter int BOARD_Y0  = BRD_Y0,
    parameter int BORDER_PX = BRD_BORDER_PX,
    parameter bit SYNC_POL  = VGA_SYNC_POL
) (
    input  logic       pixclk,
    input  logic       rst_n,
    tetris_frame_renderer_if.slave cell_if,
    output logic [7:0] R_data,
    output logic [7:0] G_data,
    output logic [7:0] B_data,
    output logic       vde,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam int CELL_SH = $clog2(CELL_PX);
    localparam int BX1 = BOARD_X0 + BOARD_COLS * CELL_PX;
    localparam int BY1 = BOARD_Y0 + BOARD_ROWS * CELL_PX;
    localparam int FX0 = BOARD_X0 - BORDER_PX;
    localparam int FY0 = BOARD_Y0 - BORDER_PX;
    localparam int FX1 = BX1 + BORDER_PX;
    localparam int FY1 = BY1 + BORDER_PX;

    localparam sync_t SYNC_IDLE = '{
        de: 1'b0,
        hs: ~SYNC_POL,
        vs: ~SYNC_POL
    };

    hcnt_t hcnt;
    vcnt_t vcnt;
    sync_t raw;

    video_timing_counter #(
        .H_VIS    (H_VIS),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_VIS    (V_VIS),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .pixclk     (pixclk),
        .rst_n      (rst_n),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .raw        (raw),
        .frame_tick (frame_tick)
    );

    color_t disp_q [BOARD_ROWS][BOARD_COLS];
    logic   wr_ok;

    assign wr_ok = cell_if.cell_we
                && (cell_if.cell_x < 4'(BOARD_COLS))
                && (cell_if.cell_y < 5'(BOARD_ROWS));

`ifdef TETRIS_BOARD_DBUF_EN
    color_t shadow_q [BOARD_ROWS][BOARD_COLS];

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < BOARD_ROWS; r++)
                for (int c = 0; c < BOARD_COLS; c++)
                    shadow_q[r][c] <= '0;
        end else if (wr_ok) begin
            shadow_q[cell_if.cell_y][cell_if.cell_x]
                <= cell_if.cell_color;
        end
    end

    // Copy takes the pre-edge shadow, so a write on this
    // same edge waits for the next frame.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < BOARD_ROWS; r++)
                for (int c = 0; c < BOARD_COLS; c++)
                    disp_q[r][c] <= '0;
        end else if (frame_tick) begin
            for (int r = 0; r < BOARD_ROWS; r++)
                for (int c = 0; c < BOARD_COLS; c++)
                    disp_q[r][c] <= shadow_q[r][c];
        end
    end
`else
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < BOARD_ROWS; r++)
                for (int c = 0; c < BOARD_COLS; c++)
                    disp_q[r][c] <= '0;
        end else if (wr_ok) begin
            disp_q[cell_if.cell_y][cell_if.cell_x]
                <= cell_if.cell_color;
        end
    end
`endif

    hcnt_t      hoff;
    vcnt_t      voff;
    logic [3:0] col;
    logic [4:0] row;
    logic       in_board;
    logic       in_frame;
    logic       in_border;
    region_t    region;
    color_t     rd_color;

    always_comb begin
        hoff      = hcnt - hcnt_t'(BOARD_X0);
        voff      = vcnt - vcnt_t'(BOARD_Y0);
        col       = 4'(hoff >> CELL_SH);
        row       = 5'(voff >> CELL_SH);
        in_board  = (hcnt >= hcnt_t'(BOARD_X0))
                 && (hcnt <  hcnt_t'(BX1))
                 && (vcnt >= vcnt_t'(BOARD_Y0))
                 && (vcnt <  vcnt_t'(BY1));
        in_frame  = (hcnt >= hcnt_t'(FX0))
                 && (hcnt <  hcnt_t'(FX1))
                 && (vcnt >= vcnt_t'(FY0))
                 && (vcnt <  vcnt_t'(FY1));
        in_border = in_frame && !in_board;
        region    = REG_BG;
        rd_color  = '0;
        unique case (1'b1)
            in_board: begin
                region   = REG_BOARD;
                rd_color = disp_q[row][col];
            end
            in_border: region = REG_BORDER;
            default:   region = REG_BG;
        endcase
    end

    s1_t   s1_q;
    sync_t s2_q;
    rgb_t  rgb_q;

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q.sy     <= SYNC_IDLE;
            s1_q.region <= REG_BG;
            s1_q.color  <= '0;
            s2_q        <= SYNC_IDLE;
            rgb_q       <= '0;
        end else begin
            s1_q.sy     <= raw;
            s1_q.region <= region;
            s1_q.color  <= rd_color;
            s2_q        <= s1_q.sy;
            if (!s1_q.sy.de) begin
                rgb_q <= '0;
            end else begin
                unique case (s1_q.region)
                    REG_BOARD:  rgb_q <= palette(s1_q.color);
                    REG_BORDER: rgb_q <= BORDER_RGB;
                    default:    rgb_q <= BG_RGB;
                endcase
            end
        end
    end

    assign {R_data, G_data, B_data} = rgb_q;
    assign vde   = s2_q.de;
    assign hsync = s2_q.hs;
    assign vsync = s2_q.vs;

endmodule
